// File: rtl/poly_mode_wrapper_ctrl.sv
// Serial-in / serial-out wrapper around a dual-mode (AES / SHA3) crypto core.
// Assembles a frame LSB first, starts the core, waits for its result, then serialises it.
module poly_mode_wrapper_ctrl #(
   parameter int unsigned DIN_W       = 1224,
   parameter int unsigned AES_OUT_W   = 256,
   parameter int unsigned SHA3_OUT_W  = 1024,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  mode_sel_i,
   input  logic                  data_in_i,
   input  logic                  data_in_valid_i,
   input  logic                  word_en_i,
   output logic                  data_req_o,
   output logic [DIN_W-1:0]      core_data_o,
   output logic                  core_mode_o,
   output logic                  core_start_o,
   input  logic                  core_done_i,
   input  logic [SHA3_OUT_W-1:0] core_result_i,
   input  logic                  out_ready_i,
   output logic                  data_out_o,
   output logic                  data_out_valid_aes_o,
   output logic                  data_out_valid_sha3_o,
   output logic                  busy_o,
   output logic                  err_timeout_o
);

   localparam int unsigned BitCntW  = (DIN_W > 1) ? $clog2(DIN_W) : 1;
   localparam int unsigned OutCntW  = (SHA3_OUT_W > 1) ? $clog2(SHA3_OUT_W) : 1;
   localparam int unsigned WaitCntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StShift} state_e;

   state_e                state_q, state_d;
   logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [OutCntW-1:0]    out_cnt_q, out_cnt_d;
   logic [DIN_W-1:0]      core_data_q, core_data_d;
   logic [SHA3_OUT_W-1:0] shift_q, shift_d;
   logic                  mode_q, mode_d;
   logic                  err_q, err_d;
   logic                  accept, last_in, last_out, timeout_hit;

   assign accept      = ((state_q == StIdle) || (state_q == StLoad)) && data_in_valid_i;
   assign last_in     = (32'(bit_cnt_q) == DIN_W - 32'd1);
   assign last_out    = (32'(out_cnt_q) == (mode_q ? SHA3_OUT_W : AES_OUT_W) - 32'd1);
   assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(wait_cnt_q) + 32'd1) == TIMEOUT_CYC);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         out_cnt_q   <= '0;
         core_data_q <= '0;
         shift_q     <= '0;
         mode_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         out_cnt_q   <= out_cnt_d;
         core_data_q <= core_data_d;
         shift_q     <= shift_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      out_cnt_d   = out_cnt_q;
      core_data_d = core_data_q;
      shift_d     = shift_q;
      mode_d      = mode_q;
      err_d       = err_q;
      unique case (state_q)
         StIdle, StLoad: begin
            if (accept) begin
               if (word_en_i) begin
                  // Frame start (or restart): bit 0 written, remaining bits overwritten later
                  core_data_d    = '0;
                  core_data_d[0] = data_in_i;
                  mode_d         = mode_sel_i;
                  err_d          = 1'b0;
                  bit_cnt_d      = (DIN_W > 1) ? BitCntW'(1) : '0;
                  state_d        = (DIN_W > 1) ? StLoad : StStart;
               end else if (state_q == StLoad) begin
                  core_data_d[bit_cnt_q] = data_in_i;
                  if (last_in) begin
                     bit_cnt_d = '0;
                     state_d   = StStart;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  end
               end
            end
         end
         StStart: begin
            wait_cnt_d = '0;
            state_d    = StWait;
         end
         StWait: begin
            if (core_done_i) begin
               shift_d    = core_result_i;
               out_cnt_d  = '0;
               wait_cnt_d = '0;
               state_d    = StShift;
            end else if (timeout_hit) begin
               err_d      = 1'b1;
               wait_cnt_d = '0;
               state_d    = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitCntW'(1);
            end
         end
         StShift: begin
            if (out_ready_i) begin
               shift_d = shift_q >> 1;
               if (last_out) begin
                  out_cnt_d = '0;
                  state_d   = StIdle;
               end else begin
                  out_cnt_d = out_cnt_q + OutCntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      data_req_o            = (state_q == StIdle) || (state_q == StLoad);
      busy_o                = (state_q != StIdle);
      core_start_o          = (state_q == StStart);
      data_out_valid_aes_o  = (state_q == StShift) && !mode_q;
      data_out_valid_sha3_o = (state_q == StShift) && mode_q;
      data_out_o            = (state_q == StShift) && shift_q[0];
   end

   assign core_data_o   = core_data_q;
   assign core_mode_o   = mode_q;
   assign err_timeout_o = err_q;

endmodule

// File: tb/tb_poly_mode_wrapper_ctrl.sv
// Randomised scoreboard bench for poly_mode_wrapper_ctrl with a frame-level reference model.
module tb_poly_mode_wrapper_ctrl;

   localparam int unsigned DIN_W       = 8;
   localparam int unsigned AES_OUT_W   = 4;
   localparam int unsigned SHA3_OUT_W  = 8;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic                  mode_sel_i, data_in_i, data_in_valid_i, word_en_i;
   logic                  data_req_o, core_mode_o, core_start_o;
   logic [DIN_W-1:0]      core_data_o;
   logic                  core_done_i, out_ready_i;
   logic [SHA3_OUT_W-1:0] core_result_i;
   logic                  data_out_o, data_out_valid_aes_o, data_out_valid_sha3_o;
   logic                  busy_o, err_timeout_o;

   poly_mode_wrapper_ctrl #(
      .DIN_W      (DIN_W),
      .AES_OUT_W  (AES_OUT_W),
      .SHA3_OUT_W (SHA3_OUT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_i                (clk_i),
      .reset_i              (reset_i),
      .mode_sel_i           (mode_sel_i),
      .data_in_i            (data_in_i),
      .data_in_valid_i      (data_in_valid_i),
      .word_en_i            (word_en_i),
      .data_req_o           (data_req_o),
      .core_data_o          (core_data_o),
      .core_mode_o          (core_mode_o),
      .core_start_o         (core_start_o),
      .core_done_i          (core_done_i),
      .core_result_i        (core_result_i),
      .out_ready_i          (out_ready_i),
      .data_out_o           (data_out_o),
      .data_out_valid_aes_o (data_out_valid_aes_o),
      .data_out_valid_sha3_o(data_out_valid_sha3_o),
      .busy_o               (busy_o),
      .err_timeout_o        (err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {logic mode; logic b;} exp_t;
   typedef struct {logic b; logic we; logic v; logic m;} st_t;

   int               n_cmp = 0;
   int               n_err = 0;
   exp_t             sb_q[$];
   st_t              st_q[$];
   logic             frm[$];
   logic             in_frame = 1'b0;
   logic             fmode = 1'b0;
   logic [DIN_W-1:0] exp_core_data = '0;
   logic             exp_mode = 1'b0;
   logic             exp_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: each valid cycle is checked against the head of the scoreboard
   always @(negedge clk_i) begin
      if (!reset_i) begin
         chk("both_valid", 64'(data_out_valid_aes_o & data_out_valid_sha3_o), 64'(0));
         if (data_out_valid_aes_o || data_out_valid_sha3_o) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got valid with empty queue at %0t", $time);
            end else begin
               chk("out_mode", 64'(data_out_valid_sha3_o), 64'(sb_q[0].mode));
               chk("out_bit", 64'(data_out_o), 64'(sb_q[0].b));
               if (out_ready_i) void'(sb_q.pop_front());
            end
         end else begin
            chk("out_idle_zero", 64'(data_out_o), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic rdy(input int pat, input int k);
      case (pat)
         0:       return 1'b1;
         1:       return (k % 2) == 0;
         default: return 1'($urandom % 2);
      endcase
   endfunction

   task automatic add(input logic b, input logic we, input logic v, input logic m);
      st_t e;
      e.b = b; e.we = we; e.v = v; e.m = m;
      st_q.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_data_req"}, 64'(data_req_o), 64'(1));
      chk({tag, "_core_start"}, 64'(core_start_o), 64'(0));
      chk({tag, "_data_out"}, 64'(data_out_o), 64'(0));
      chk({tag, "_valid_aes"}, 64'(data_out_valid_aes_o), 64'(0));
      chk({tag, "_valid_sha3"}, 64'(data_out_valid_sha3_o), 64'(0));
      chk({tag, "_busy"}, 64'(busy_o), 64'(0));
      chk({tag, "_err"}, 64'(err_timeout_o), 64'(0));
      chk({tag, "_core_data"}, 64'(core_data_o), 64'(0));
      chk({tag, "_core_mode"}, 64'(core_mode_o), 64'(0));
   endtask

   // Drive the queued serial stream; the model rebuilds the frame from accepted bits
   task automatic stream();
      st_t e;
      while (st_q.size() > 0) begin
         e = st_q.pop_front();
         mode_sel_i = e.m; data_in_i = e.b; word_en_i = e.we; data_in_valid_i = e.v;
         @(negedge clk_i);
         chk("data_req_load", 64'(data_req_o), 64'(1));
         chk("no_early_start", 64'(core_start_o), 64'(0));
         if (e.v) begin
            if (e.we) begin
               frm.delete();
               frm.push_back(e.b);
               fmode = e.m;
               in_frame = 1'b1;
               exp_err = 1'b0;
            end else if (in_frame) begin
               frm.push_back(e.b);
            end
         end
         tick();
         chk("err_load", 64'(err_timeout_o), 64'(exp_err));
         if (in_frame) chk("mode_load", 64'(core_mode_o), 64'(fmode));
         if (in_frame && frm.size() == DIN_W) begin
            for (int k = 0; k < int'(DIN_W); k++) exp_core_data[k] = frm[k];
            exp_mode = fmode;
            in_frame = 1'b0;
            st_q.delete();
         end
      end
      data_in_valid_i = 1'b0; word_en_i = 1'b0;
      data_in_i = 1'($urandom); mode_sel_i = 1'($urandom);
   endtask

   task automatic expect_start();
      @(negedge clk_i);
      chk("core_start", 64'(core_start_o), 64'(1));
      chk("core_data", 64'(core_data_o), 64'(exp_core_data));
      chk("core_mode", 64'(core_mode_o), 64'(exp_mode));
      chk("busy_start", 64'(busy_o), 64'(1));
      chk("data_req_start", 64'(data_req_o), 64'(0));
      tick();
      @(negedge clk_i);
      chk("start_one_pulse", 64'(core_start_o), 64'(0));
   endtask

   task automatic run_wait(input int done_at, input logic [SHA3_OUT_W-1:0] res, input int pat,
                           output logic timed_out);
      exp_t x;
      int   len;
      for (int w = 1; w < done_at && w <= int'(TIMEOUT_CYC); w++) begin
         core_result_i = SHA3_OUT_W'($urandom);
         tick();
      end
      if (done_at <= int'(TIMEOUT_CYC)) begin
         len = exp_mode ? int'(SHA3_OUT_W) : int'(AES_OUT_W);
         for (int j = 0; j < len; j++) begin
            x.mode = exp_mode;
            x.b    = res[j];
            sb_q.push_back(x);
         end
         core_done_i = 1'b1; core_result_i = res; out_ready_i = rdy(pat, 0);
         tick();
         core_done_i = 1'b0; core_result_i = SHA3_OUT_W'($urandom);
         @(negedge clk_i);
         chk("first_valid_aes", 64'(data_out_valid_aes_o), 64'(!exp_mode));
         chk("first_valid_sha3", 64'(data_out_valid_sha3_o), 64'(exp_mode));
         chk("core_data_hold", 64'(core_data_o), 64'(exp_core_data));
         timed_out = 1'b0;
      end else begin
         exp_err = 1'b1;
         @(negedge clk_i);
         chk("timeout_err", 64'(err_timeout_o), 64'(1));
         chk("timeout_busy", 64'(busy_o), 64'(0));
         chk("timeout_data_req", 64'(data_req_o), 64'(1));
         timed_out = 1'b1;
      end
   endtask

   task automatic run_shift(input int pat);
      int  k = 0;
      logic done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         tick();
         k++;
         out_ready_i = rdy(pat, k);
         @(negedge clk_i);
         if (!busy_o) done = 1'b1;
      end
      chk("shift_finished", 64'(done), 64'(1));
      chk("sb_drained", 64'(sb_q.size()), 64'(0));
      chk("end_valid_aes", 64'(data_out_valid_aes_o), 64'(0));
      chk("end_valid_sha3", 64'(data_out_valid_sha3_o), 64'(0));
      chk("end_data_req", 64'(data_req_o), 64'(1));
      out_ready_i = 1'($urandom);
   endtask

   task automatic txn(input int done_at, input logic [SHA3_OUT_W-1:0] res, input int pat);
      logic to;
      stream();
      expect_start();
      run_wait(done_at, res, pat, to);
      if (!to) run_shift(pat);
   endtask

   task automatic build_frame(input logic m, input logic [DIN_W-1:0] bits, input logic noisy);
      if (noisy) for (int j = 0; j < int'($urandom_range(0, 2)); j++) add(1'($urandom), 1'b0, 1'b1, m);
      for (int i = 0; i < int'(DIN_W); i++) begin
         if (noisy && ($urandom % 3 == 0)) add(1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
         add(bits[i], i == 0, 1'b1, m);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic to;
      reset_i = 1'b1;
      mode_sel_i = 1'b0; data_in_i = 1'b0; data_in_valid_i = 1'b0; word_en_i = 1'b0;
      core_done_i = 1'b0; core_result_i = '0; out_ready_i = 1'b0;
      #3;
      check_reset_vals("reset");
      tick();
      tick();
      reset_i = 1'b0;

      // AES frame 1,0,1,1,0,0,1,0 -> core_data 0x4D, result 0xA5 -> 1,0,1,0
      build_frame(1'b0, 8'b0100_1101, 1'b0);
      txn(3, 8'hA5, 0);

      // SHA3 frame, out_ready toggling
      build_frame(1'b1, 8'($urandom), 1'b0);
      txn(2, 8'hA5, 1);

      // Restart at bit 5 with the opposite mode
      for (int i = 0; i < 5; i++) add(1'($urandom), i == 0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) add(1'($urandom), i == 0, 1'b1, 1'b1);
      txn(5, 8'($urandom), 2);

      // Timeout: no core_done within the window
      build_frame(1'b0, 8'($urandom), 1'b0);
      txn(TIMEOUT_CYC + 1, 8'h00, 0);

      // Idle noise: word_en=0 bits and core_done pulses must do nothing
      for (int i = 0; i < 6; i++) begin
         data_in_valid_i = 1'b1; word_en_i = 1'b0; data_in_i = 1'($urandom);
         core_done_i = i[0]; core_result_i = 8'($urandom);
         tick();
         @(negedge clk_i);
         chk("idle_busy", 64'(busy_o), 64'(0));
         chk("idle_data_req", 64'(data_req_o), 64'(1));
         chk("idle_err_kept", 64'(err_timeout_o), 64'(exp_err));
         chk("idle_core_data", 64'(core_data_o), 64'(exp_core_data));
      end
      data_in_valid_i = 1'b0; core_done_i = 1'b0;

      // core_done on the last permitted WAIT cycle beats the timeout
      build_frame(1'b1, 8'($urandom), 1'b0);
      txn(TIMEOUT_CYC, 8'($urandom), 0);

      // Reset in SHIFT after two of eight bits
      build_frame(1'b1, 8'($urandom), 1'b0);
      stream();
      expect_start();
      run_wait(2, 8'h3C, 0, to);
      tick();
      tick();
      reset_i = 1'b1;
      #1;
      check_reset_vals("mid_reset");
      sb_q.delete();
      in_frame = 1'b0; exp_core_data = '0; exp_mode = 1'b0; exp_err = 1'b0;
      tick();
      reset_i = 1'b0;
      build_frame(1'b0, 8'($urandom), 1'b0);
      txn(4, 8'($urandom), 2);

      // Randomised frames with valid gaps and leading junk
      for (int n = 0; n < 12; n++) begin
         build_frame(1'($urandom), 8'($urandom), 1'b1);
         txn(int'($urandom_range(1, TIMEOUT_CYC)), 8'($urandom), int'($urandom_range(0, 2)));
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/poly_mode_wrapper_ctrl.md
POLY_MODE_WRAPPER_CTRL -- requirements
Module: poly_mode_wrapper_ctrl

Interface
REQ-001 The block SHALL have parameter DIN_W, default 1224, meaning the serial input frame length in bits and the core_data width.
REQ-002 The block SHALL have parameter AES_OUT_W, default 256, meaning the number of result bits serialised in AES mode.
REQ-003 The block SHALL have parameter SHA3_OUT_W, default 1024, meaning the number of result bits serialised in SHA3 mode and the core_result width; SHA3_OUT_W >= AES_OUT_W.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning the maximum number of WAIT cycles; 0 disables the timeout.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1, the single clock with all state on its rising edge; reset in 1, the asynchronous active-high reset.
REQ-006 The block SHALL have ports:
  mode_sel  in  1  0 = AES, 1 = SHA3; sampled with the frame-start bit
  data_in  in  1  serial frame bit
  data_in_valid  in  1  data_in qualifier
  word_en  in  1  marks the first bit of a frame
  data_req  out  1  ready to accept serial bits
  core_data  out  DIN_W  assembled frame to the core
  core_mode  out  1  latched mode to the core
  core_start  out  1  one-cycle start pulse
  core_done  in  1  core result valid, sampled in WAIT only
  core_result  in  SHA3_OUT_W  core result; AES uses bits [AES_OUT_W-1:0]
  out_ready  in  1  downstream accepts a serial output bit
  data_out  out  1  serial result bit
  data_out_valid_aes  out  1  data_out valid, AES frame
  data_out_valid_sha3  out  1  data_out valid, SHA3 frame
  busy  out  1  state is not IDLE
  err_timeout  out  1  sticky timeout flag

Function
REQ-007 The FSM SHALL have states IDLE, LOAD, START, WAIT and SHIFT.
REQ-008 data_req SHALL be 1 in IDLE and LOAD and 0 otherwise; a bit is accepted when data_req && data_in_valid.
REQ-009 In IDLE, an accepted bit with word_en=0 SHALL be discarded.
REQ-010 In IDLE, an accepted bit with word_en=1 SHALL be stored as frame bit 0, latch mode_sel into core_mode, clear err_timeout, and move to LOAD.
REQ-011 Frame bit k SHALL be written to core_data[k] (LSB first); the in-frame bit counter SHALL count 0..DIN_W-1 with no wrap past DIN_W-1.
REQ-012 In LOAD, an accepted bit with word_en=1 SHALL restart the frame: that bit becomes bit 0, the counter resets, and mode_sel is re-latched.
REQ-013 When bit DIN_W-1 is accepted (cycle N), the FSM SHALL enter START; core_start SHALL be 1 only in cycle N+1, then the FSM enters WAIT.
REQ-014 core_data SHALL hold the full frame stable from START until the next frame-start bit is accepted.
REQ-015 In WAIT, core_done=1 SHALL capture core_result into the output shift register and move to SHIFT; core_done outside WAIT SHALL be ignored.
REQ-016 In WAIT, the cycle counter SHALL increment each cycle. If TIMEOUT_CYC > 0 and the counter reaches TIMEOUT_CYC without core_done, err_timeout SHALL set and the FSM returns to IDLE. core_done in that same cycle wins over the timeout.
REQ-017 In SHIFT, data_out SHALL present result bit j, LSB first. The valid output matching core_mode SHALL be 1 and the other 0; j advances only in a cycle with out_ready=1.
REQ-018 The first data_out valid SHALL occur in the cycle after core_done; the output length SHALL be AES_OUT_W bits (AES) or SHA3_OUT_W bits (SHA3).
REQ-019 After the last output bit is accepted with out_ready=1, the FSM SHALL return to IDLE in the next cycle with both valid outputs 0.
REQ-020 Both valid outputs SHALL never be 1 in the same cycle; data_out SHALL be 0 when neither valid output is 1.
REQ-021 busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 While reset=1, regardless of clk: FSM=IDLE, all counters 0, core_data=0, core_mode=0, shift register=0; outputs data_req=1, core_start=0, data_out=0, both valid outputs 0, busy=0, err_timeout=0.
REQ-023 Reset asserted mid-frame, mid-WAIT or mid-SHIFT SHALL discard the operation; after release the block accepts only a new word_en frame.

Verification (DIN_W=8, AES_OUT_W=4, SHA3_OUT_W=8, TIMEOUT_CYC=16)
REQ-024 AES frame: mode_sel=0, bits 1,0,1,1,0,0,1,0 (word_en on the first), core_done after 3 WAIT cycles with core_result=0xA5 -> core_data=0x4D; core_start is one pulse; data_out_valid_aes is high for 4 bits 1,0,1,0; data_out_valid_sha3 stays 0.
REQ-025 SHA3 frame with core_result=0xA5 and out_ready toggling 1,0,1,0... -> 8 bits 1,0,1,0,0,1,0,1; each bit is held while out_ready=0; data_out_valid_sha3 stays high until bit 7 is accepted.
REQ-026 Restart: word_en=1 at bit 5 of a frame, then 7 more bits -> core_start only after the 8th post-restart bit; core_mode equals mode_sel at the restart.
REQ-027 Timeout: no core_done for 16 WAIT cycles -> err_timeout=1, busy=0, data_req=1; the next word_en bit clears err_timeout.
REQ-028 Reset asserted in SHIFT after 2 of 8 bits -> all outputs immediately at REQ-022 values; a following frame completes normally.
REQ-029 Bits with word_en=0 in IDLE, and core_done pulsed in IDLE -> no state change and no output activity.
